// File: rtl/c2h_queue_scheduler_if.sv
// ---------------------------------------------------------------------------
// c2h_queue_scheduler_if
// Grant / completion handshake between the C2H queue scheduler and the
// traffic generator.
//   sched_valid  : scheduler -> generator, grant valid
//   sched_ready  : generator -> scheduler, grant accepted
//   sched_qid    : scheduler -> generator, granted queue id
//   sched_credit : scheduler -> generator, credits granted for the packet
//   pkt_done     : generator -> scheduler, 1-cycle strobe on last beat
// Modports: master = scheduler side, slave = generator side.
// ---------------------------------------------------------------------------
interface c2h_queue_scheduler_if #(
    parameter int QID_W       = 4,
    parameter int TM_DSC_BITS = 16
);
    logic                   sched_valid;
    logic                   sched_ready;
    logic [QID_W-1:0]       sched_qid;
    logic [TM_DSC_BITS-1:0] sched_credit;
    logic                   pkt_done;

    modport master (
        output sched_valid,
        output sched_qid,
        output sched_credit,
        input  sched_ready,
        input  pkt_done
    );

    modport slave (
        input  sched_valid,
        input  sched_qid,
        input  sched_credit,
        output sched_ready,
        output pkt_done
    );
endinterface

// File: rtl/c2h_queue_scheduler.sv
// ---------------------------------------------------------------------------
// c2h_queue_scheduler
// Round-robin scheduler that hands one packet grant at a time to the C2H
// traffic generator, across NUM_Q queues, based on per-queue credit counters.
// Ports:
//   axi_aclk / axi_areset : clock, synchronous active-high reset
//   control_reg           : [1]=run, [8+NUM_Q-1:8]=queue enable mask
//   num_pkt               : packets per enabled queue per run (0 = unlimited)
//   credit_perpkt_in      : credits consumed per packet (latched at run start)
//   credit_updt/qid/in    : 1-cycle strobe adding credit_in to one queue
//   sched                 : grant handshake + pkt_done (interface, master)
//   busy                  : run in progress
//   all_done              : 1-cycle pulse when every enabled queue sent num_pkt
//   credit_avail          : packed credit counters, queue q at [q*TM +: TM]
// ---------------------------------------------------------------------------
module c2h_queue_scheduler #(
    parameter int NUM_Q       = 4,
    parameter int QID_W       = 4,
    parameter int TM_DSC_BITS = 16
) (
    input  logic                         axi_aclk,
    input  logic                         axi_areset,
    input  logic [31:0]                  control_reg,
    input  logic [15:0]                  num_pkt,
    input  logic [TM_DSC_BITS-1:0]       credit_perpkt_in,
    input  logic                         credit_updt,
    input  logic [QID_W-1:0]             credit_qid,
    input  logic [TM_DSC_BITS-1:0]       credit_in,
    c2h_queue_scheduler_if.master        sched,
    output logic                         busy,
    output logic                         all_done,
    output logic [NUM_Q*TM_DSC_BITS-1:0] credit_avail
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_ARB       = 2'd1;
    localparam logic [1:0] S_ISSUE     = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;

    // cnt + add - sub, clamped to the counter range. Underflow cannot occur
    // in practice (a queue is only granted with cnt >= perpkt) but clamps to 0.
    function automatic logic [TM_DSC_BITS-1:0] sat_upd(
        input logic [TM_DSC_BITS-1:0] cnt,
        input logic [TM_DSC_BITS-1:0] add,
        input logic [TM_DSC_BITS-1:0] sub
    );
        logic [TM_DSC_BITS+1:0] t;
        t = {2'b00, cnt} + {2'b00, add} - {2'b00, sub};
        if (t[TM_DSC_BITS+1]) begin
            sat_upd = '0;
        end else if (t[TM_DSC_BITS]) begin
            sat_upd = '1;
        end else begin
            sat_upd = t[TM_DSC_BITS-1:0];
        end
    endfunction

    logic [1:0]             state_q, state_d;
    logic                   valid_q, valid_d;
    logic [QID_W-1:0]       qid_q, qid_d;
    logic [TM_DSC_BITS-1:0] credit_q, credit_d;
    logic [QID_W-1:0]       rr_q, rr_d;
    logic [TM_DSC_BITS-1:0] perpkt_q, perpkt_d;
    logic                   all_done_q, all_done_d;
    logic                   busy_q;
    logic                   run_q;
    logic [TM_DSC_BITS-1:0] cnt_q [NUM_Q];
    logic [TM_DSC_BITS-1:0] cnt_d [NUM_Q];
    logic [15:0]            sent_q [NUM_Q];
    logic [15:0]            sent_d [NUM_Q];

    logic                   run_s;
    logic [NUM_Q-1:0]       en_s;
    logic [NUM_Q-1:0]       elig_s;
    logic                   hs_s;
    logic                   found_s;
    logic [QID_W-1:0]       pick_s;
    logic                   done_all_s;
    logic                   sent_clr_s;
    logic                   unused_ctl_s;

    assign run_s        = control_reg[1];
    assign en_s         = control_reg[8 +: NUM_Q];
    assign unused_ctl_s = ^{control_reg[31:8+NUM_Q], control_reg[7:2], control_reg[0]};
    assign hs_s         = (state_q == S_ISSUE) && valid_q && sched.sched_ready;

    assign sched.sched_valid  = valid_q;
    assign sched.sched_qid    = qid_q;
    assign sched.sched_credit = credit_q;
    assign busy               = busy_q;
    assign all_done           = all_done_q;

    // Per-queue eligibility and run-completion detection.
    always_comb begin
        elig_s     = '0;
        done_all_s = (num_pkt != 16'd0) && (en_s != '0);
        for (int q = 0; q < NUM_Q; q++) begin
            elig_s[q] = en_s[q] && (cnt_q[q] >= perpkt_q) &&
                        ((num_pkt == 16'd0) || (sent_q[q] < num_pkt));
            if (en_s[q] && (sent_q[q] < num_pkt)) begin
                done_all_s = 1'b0;
            end else begin
                done_all_s = done_all_s;
            end
        end
    end

    // Round-robin pick: first eligible queue scanning rr+1, rr+2, ... mod NUM_Q.
    always_comb begin
        int idx;
        found_s = 1'b0;
        pick_s  = '0;
        idx     = 0;
        for (int k = 1; k <= NUM_Q; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_Q) begin
                idx = idx - NUM_Q;
            end else begin
                idx = idx;
            end
            if (!found_s && elig_s[idx]) begin
                found_s = 1'b1;
                pick_s  = QID_W'(idx);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Scheduler FSM next-state and grant register next values.
    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        qid_d      = qid_q;
        credit_d   = credit_q;
        rr_d       = rr_q;
        perpkt_d   = perpkt_q;
        all_done_d = 1'b0;
        sent_clr_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Only a rising edge of run starts a run, so a completed run
                // stays idle until run is cycled.
                if (run_s && !run_q) begin
                    perpkt_d   = (credit_perpkt_in == '0) ? TM_DSC_BITS'(1) : credit_perpkt_in;
                    sent_clr_s = 1'b1;
                    state_d    = S_ARB;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ARB: begin
                if (!run_s) begin
                    state_d = S_IDLE;
                end else if (found_s) begin
                    qid_d    = pick_s;
                    credit_d = perpkt_q;
                    rr_d     = pick_s;
                    valid_d  = 1'b1;
                    state_d  = S_ISSUE;
                end else begin
                    state_d = S_ARB;
                end
            end
            S_ISSUE: begin
                // The grant is never withdrawn; run is ignored until accepted.
                if (hs_s) begin
                    valid_d = 1'b0;
                    state_d = S_WAIT_DONE;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_WAIT_DONE: begin
                if (sched.pkt_done) begin
                    if (done_all_s) begin
                        all_done_d = 1'b1;
                        state_d    = S_IDLE;
                    end else if (!run_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_ARB;
                    end
                end else begin
                    state_d = S_WAIT_DONE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Credit and sent-count next values; an update and a deduction in the
    // same cycle on the same queue are merged so neither is lost.
    always_comb begin
        for (int q = 0; q < NUM_Q; q++) begin
            cnt_d[q] = sat_upd(cnt_q[q],
                               (credit_updt && (credit_qid == QID_W'(q))) ? credit_in : '0,
                               (hs_s && (qid_q == QID_W'(q))) ? perpkt_q : '0);
            sent_d[q] = sent_clr_s ? 16'd0 :
                        ((hs_s && (qid_q == QID_W'(q))) ? (sent_q[q] + 16'd1) : sent_q[q]);
        end
    end

    // Pack credit counters for observation.
    always_comb begin
        credit_avail = '0;
        for (int q = 0; q < NUM_Q; q++) begin
            credit_avail[q*TM_DSC_BITS +: TM_DSC_BITS] = cnt_q[q];
        end
    end

    // FSM, grant outputs and status registers.
    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            state_q    <= S_IDLE;
            valid_q    <= 1'b0;
            qid_q      <= '0;
            credit_q   <= '0;
            rr_q       <= QID_W'(NUM_Q - 1);
            perpkt_q   <= TM_DSC_BITS'(1);
            all_done_q <= 1'b0;
            busy_q     <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            qid_q      <= qid_d;
            credit_q   <= credit_d;
            rr_q       <= rr_d;
            perpkt_q   <= perpkt_d;
            all_done_q <= all_done_d;
            busy_q     <= (state_d != S_IDLE);
            run_q      <= run_s;
        end
    end

    // Per-queue credit and sent counters.
    always_ff @(posedge axi_aclk) begin
        for (int q = 0; q < NUM_Q; q++) begin
            if (axi_areset) begin
                cnt_q[q]  <= '0;
                sent_q[q] <= 16'd0;
            end else begin
                cnt_q[q]  <= cnt_d[q];
                sent_q[q] <= sent_d[q];
            end
        end
    end

endmodule

// File: tb/tb_c2h_queue_scheduler.sv
module tb_c2h_queue_scheduler;

    logic        clk;
    logic        axi_areset;
    logic [31:0] control_reg;
    logic [15:0] num_pkt;
    logic [15:0] credit_perpkt_in;
    logic        credit_updt;
    logic [3:0]  credit_qid;
    logic [15:0] credit_in;
    logic        busy;
    logic        all_done;
    logic [63:0] credit_avail;

    int checks = 0;
    int errors = 0;

    c2h_queue_scheduler_if #(.QID_W(4), .TM_DSC_BITS(16)) sif ();

    c2h_queue_scheduler #(.NUM_Q(4), .QID_W(4), .TM_DSC_BITS(16)) dut (
        .axi_aclk         (clk),
        .axi_areset       (axi_areset),
        .control_reg      (control_reg),
        .num_pkt          (num_pkt),
        .credit_perpkt_in (credit_perpkt_in),
        .credit_updt      (credit_updt),
        .credit_qid       (credit_qid),
        .credit_in        (credit_in),
        .sched            (sif),
        .busy             (busy),
        .all_done         (all_done),
        .credit_avail     (credit_avail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ctl(input logic run, input logic [3:0] en);
        ctl = {20'd0, en, 6'd0, run, 1'b0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_dut();
        axi_areset = 1'b1;
        step();
        step();
        axi_areset = 1'b0;
    endtask

    task automatic add_credit(input logic [3:0] q, input logic [15:0] amt);
        credit_updt = 1'b1;
        credit_qid  = q;
        credit_in   = amt;
        step();
        credit_updt = 1'b0;
        credit_qid  = 4'd0;
        credit_in   = 16'd0;
    endtask

    task automatic wait_valid();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (sif.sched_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
            step();
        end
        chk("grant_timeout", 32'(got), 32'd1);
    endtask

    task automatic pkt(input int dly);
        repeat (dly) step();
        sif.pkt_done = 1'b1;
        step();
        sif.pkt_done = 1'b0;
    endtask

    int  exp3a [4] = '{0, 2, 0, 2};
    int  exp3b [5] = '{0, 1, 2, 0, 2};
    bit  stable;
    bit  seen;

    initial begin
        axi_areset       = 1'b1;
        control_reg      = 32'd0;
        num_pkt          = 16'd0;
        credit_perpkt_in = 16'd0;
        credit_updt      = 1'b0;
        credit_qid       = 4'd0;
        credit_in        = 16'd0;
        sif.sched_ready  = 1'b0;
        sif.pkt_done     = 1'b0;
        repeat (3) step();

        // ---- reset values ----
        chk("rst_valid",  32'(sif.sched_valid),  32'd0);
        chk("rst_qid",    32'(sif.sched_qid),    32'd0);
        chk("rst_credit", 32'(sif.sched_credit), 32'd0);
        chk("rst_busy",   32'(busy),             32'd0);
        chk("rst_alldn",  32'(all_done),         32'd0);
        chk("rst_cav_lo", credit_avail[31:0],    32'd0);
        chk("rst_cav_hi", credit_avail[63:32],   32'd0);
        axi_areset = 1'b0;
        step();

        // ---- 1: single queue, two packets of 7 credits ----
        add_credit(4'd0, 16'd14);
        chk("t1_cnt0_init", 32'(credit_avail[15:0]), 32'd14);
        num_pkt          = 16'd2;
        credit_perpkt_in = 16'd7;
        sif.sched_ready  = 1'b1;
        control_reg      = ctl(1'b1, 4'h1);
        for (int g = 0; g < 2; g++) begin
            wait_valid();
            chk("t1_qid",    32'(sif.sched_qid),    32'd0);
            chk("t1_credit", 32'(sif.sched_credit), 32'd7);
            step();
            chk("t1_valid_drop", 32'(sif.sched_valid), 32'd0);
            chk("t1_cnt0", 32'(credit_avail[15:0]), 32'(14 - 7 * (g + 1)));
            pkt(10);
        end
        chk("t1_alldone", 32'(all_done), 32'd1);
        chk("t1_busy",    32'(busy),     32'd0);
        step();
        chk("t1_alldone_pulse", 32'(all_done), 32'd0);

        // ---- 2: four queues, round-robin order ----
        control_reg = ctl(1'b0, 4'hF);
        reset_dut();
        for (int q = 0; q < 4; q++) add_credit(4'(q), 16'd100);
        credit_perpkt_in = 16'd1;
        num_pkt          = 16'd3;
        control_reg      = ctl(1'b1, 4'hF);
        for (int i = 0; i < 12; i++) begin
            wait_valid();
            chk("t2_qid", 32'(sif.sched_qid), 32'(i % 4));
            step();
            pkt(2);
        end
        chk("t2_alldone", 32'(all_done), 32'd1);
        chk("t2_cnt3",    32'(credit_avail[63:48]), 32'd97);
        step();
        chk("t2_busy", 32'(busy), 32'd0);

        // ---- 3: queue 1 starved, then given one credit ----
        control_reg = ctl(1'b0, 4'h7);
        reset_dut();
        add_credit(4'd0, 16'd100);
        add_credit(4'd2, 16'd100);
        add_credit(4'd3, 16'd100);
        credit_perpkt_in = 16'd1;
        num_pkt          = 16'd0;
        control_reg      = ctl(1'b1, 4'h7);
        for (int i = 0; i < 4; i++) begin
            wait_valid();
            chk("t3_qid_a", 32'(sif.sched_qid), 32'(exp3a[i]));
            step();
            pkt(2);
        end
        add_credit(4'd1, 16'd1);
        for (int i = 0; i < 5; i++) begin
            wait_valid();
            chk("t3_qid_b", 32'(sif.sched_qid), 32'(exp3b[i]));
            step();
            pkt(2);
        end
        control_reg = ctl(1'b0, 4'h7);
        step();
        chk("t3_busy",  32'(busy),                  32'd0);
        chk("t3_valid", 32'(sif.sched_valid),       32'd0);
        chk("t3_cnt1",  32'(credit_avail[31:16]),   32'd0);

        // ---- 4: same-cycle update and deduction, saturation ----
        control_reg = ctl(1'b0, 4'h1);
        reset_dut();
        add_credit(4'd0, 16'd7);
        credit_perpkt_in = 16'd7;
        num_pkt          = 16'd1;
        control_reg      = ctl(1'b1, 4'h1);
        wait_valid();
        credit_updt = 1'b1;
        credit_qid  = 4'd0;
        credit_in   = 16'd5;
        step();
        credit_updt = 1'b0;
        credit_in   = 16'd0;
        chk("t4_cnt0_merge", 32'(credit_avail[15:0]), 32'd5);
        pkt(2);
        chk("t4_alldone", 32'(all_done), 32'd1);
        add_credit(4'd2, 16'hFFF0);
        chk("t4_cnt2_pre", 32'(credit_avail[47:32]), 32'h0000FFF0);
        add_credit(4'd2, 16'h0020);
        chk("t4_cnt2_sat", 32'(credit_avail[47:32]), 32'h0000FFFF);
        add_credit(4'd5, 16'd3);
        chk("t4_badqid_lo", credit_avail[31:0],  32'h00000005);
        chk("t4_badqid_hi", credit_avail[63:32], 32'h0000FFFF);

        // ---- 5: back-pressure with run dropped mid-issue ----
        control_reg = ctl(1'b0, 4'h1);
        reset_dut();
        add_credit(4'd0, 16'd10);
        credit_perpkt_in = 16'd3;
        num_pkt          = 16'd0;
        sif.sched_ready  = 1'b0;
        control_reg      = ctl(1'b1, 4'h1);
        wait_valid();
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 5) control_reg = ctl(1'b0, 4'h1);
            if (sif.sched_valid !== 1'b1 || sif.sched_qid !== 4'd0 || sif.sched_credit !== 16'd3)
                stable = 1'b0;
        end
        chk("t5_stable", 32'(stable), 32'd1);
        chk("t5_credit", 32'(sif.sched_credit), 32'd3);
        sif.sched_ready = 1'b1;
        step();
        chk("t5_valid_drop", 32'(sif.sched_valid), 32'd0);
        chk("t5_busy_wait",  32'(busy),            32'd1);
        chk("t5_cnt0",       32'(credit_avail[15:0]), 32'd7);
        pkt(3);
        chk("t5_busy_idle", 32'(busy),     32'd0);
        chk("t5_alldone",   32'(all_done), 32'd0);
        seen = 1'b0;
        repeat (10) begin
            step();
            if (sif.sched_valid !== 1'b0) seen = 1'b1;
        end
        chk("t5_no_grant", 32'(seen), 32'd0);

        // ---- 6: reset during WAIT_DONE, stale pkt_done ----
        control_reg = ctl(1'b0, 4'h1);
        reset_dut();
        add_credit(4'd0, 16'd10);
        credit_perpkt_in = 16'd1;
        num_pkt          = 16'd0;
        control_reg      = ctl(1'b1, 4'h1);
        wait_valid();
        step();
        chk("t6_busy_pre", 32'(busy), 32'd1);
        axi_areset = 1'b1;
        step();
        chk("t6_valid",  32'(sif.sched_valid),  32'd0);
        chk("t6_qid",    32'(sif.sched_qid),    32'd0);
        chk("t6_credit", 32'(sif.sched_credit), 32'd0);
        chk("t6_busy",   32'(busy),             32'd0);
        chk("t6_alldn",  32'(all_done),         32'd0);
        chk("t6_cav_lo", credit_avail[31:0],    32'd0);
        chk("t6_cav_hi", credit_avail[63:32],   32'd0);
        axi_areset   = 1'b0;
        sif.pkt_done = 1'b1;
        step();
        sif.pkt_done = 1'b0;
        chk("t6_alldn_post", 32'(all_done), 32'd0);
        seen = 1'b0;
        repeat (10) begin
            step();
            if (sif.sched_valid !== 1'b0) seen = 1'b1;
        end
        chk("t6_no_grant", 32'(seen), 32'd0);
        chk("t6_cav_post", credit_avail[31:0], 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
